axil_read_responder: RTL and testbench



---
 rtl/axil_pkg.sv | 22 ++
 rtl/axil_rresp_fifo.sv | 54 +++++
 rtl/axil_read_responder.sv | 134 +++++++++++++
 tb/tb_axil_read_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite read responder.
package axil_pkg;

    // Widest supported R data bus; narrower buses use the low bits of an entry.
    localparam int unsigned AXIL_DATA_BYTES = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef struct packed {
        resp_t                        resp;
        logic [AXIL_DATA_BYTES*8-1:0] data;
    } rresp_entry_t;

    // Address bits below the register index for a given data width.
    function automatic int unsigned axil_byte_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_rresp_fifo.sv
// First-word-fall-through response buffer; pointers carry an extra wrap bit.
module axil_rresp_fifo
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         r_reset,
    input  logic         wr_en,
    input  rresp_entry_t wr_data,
    input  logic         rd_en,
    output rresp_entry_t rd_data,
    output logic         empty,
    output logic         full
);

    rresp_entry_t     mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    // Wrap at DEPTH-1 so non-power-of-two depths still work.
    function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] ptr);
        if (ptr[PTR_W-1:0] == PTR_W'(DEPTH - 1)) begin
            return {~ptr[PTR_W], {PTR_W{1'b0}}};
        end
        return ptr + 1'b1;
    endfunction

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

    wr_when_full_a: assert property (@(posedge clk) disable iff (r_reset) !(wr_en && full));
    rd_when_empty_a: assert property (@(posedge clk) disable iff (r_reset) !(rd_en && empty));

endmodule

// File: rtl/axil_read_responder.sv
// AXI-Lite read slave: decodes AR into a register index, issues a fixed-latency
// register-file read and returns buffered responses in order.
module axil_read_responder
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_reg_rd_en,
    output logic [IDX_W-1:0]      o_reg_rd_idx,
    input  logic [DATA_WIDTH-1:0] i_reg_rd_data,
    output logic [CNT_W-1:0]      o_outstanding
);

    localparam int unsigned BYTE_SHIFT = axil_byte_shift(DATA_WIDTH);

    logic                  accept;
    logic                  pop;
    logic                  in_range;
    logic                  borrow;
    logic [ADDR_WIDTH-1:0] off;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [RD_LATENCY-1:0] pipe_valid_q;
    logic [RD_LATENCY-1:0] pipe_in_range_q;
    logic                  fifo_wr_en;
    rresp_entry_t          fifo_wr_data;
    rresp_entry_t          fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  unused_data_hi;

    // Credits come from the registered count only, so a pop never frees a slot
    // combinationally.
    assign o_arready = !i_reset && (cnt_q < CNT_W'(DEPTH));
    assign accept    = i_arvalid && o_arready;

    // Address decode; borrow flags addresses below the base.
    always_comb begin
        {borrow, off} = {1'b0, i_araddr} - {1'b0, BASE_ADDR};
        in_range      = !borrow && (off[BYTE_SHIFT-1:0] == '0) &&
                        ((off >> BYTE_SHIFT) < ADDR_WIDTH'(NUM_REGS));
        o_reg_rd_en   = accept && in_range;
        o_reg_rd_idx  = o_reg_rd_en ? IDX_W'(off >> BYTE_SHIFT) : '0;
    end

    // Read pipeline tracking which accepted requests expect register data.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            pipe_valid_q    <= '0;
            pipe_in_range_q <= '0;
        end else begin
            pipe_valid_q[0]    <= accept;
            pipe_in_range_q[0] <= in_range;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_q[i]    <= pipe_valid_q[i-1];
                pipe_in_range_q[i] <= pipe_in_range_q[i-1];
            end
        end
    end

    // Final pipeline stage captures register data into the response buffer.
    always_comb begin
        fifo_wr_en        = pipe_valid_q[RD_LATENCY-1];
        fifo_wr_data      = '0;
        fifo_wr_data.resp = SLVERR;
        if (pipe_in_range_q[RD_LATENCY-1]) begin
            fifo_wr_data.resp                 = OKAY;
            fifo_wr_data.data[DATA_WIDTH-1:0] = i_reg_rd_data;
        end
    end

    axil_rresp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .r_reset (i_reset),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // R channel outputs, zeroed whenever no beat is presented.
    always_comb begin
        o_rvalid      = !i_reset && !fifo_empty;
        pop           = o_rvalid && i_rready;
        o_rdata       = o_rvalid ? fifo_rd_data.data[DATA_WIDTH-1:0] : '0;
        o_rresp       = o_rvalid ? fifo_rd_data.resp : '0;
        o_outstanding = i_reset ? '0 : cnt_q;
    end

    assign unused_data_hi = ^fifo_rd_data.data;

    // Outstanding-credit next state.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !accept) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outstanding-credit register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    credit_bound_a: assert property (@(posedge clk) disable iff (i_reset)
        !(fifo_wr_en && fifo_full) && (cnt_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_axil_read_responder.sv
// Directed bench: instance a uses defaults, instance b uses 64-bit data and
// three-cycle register latency.
module tb_axil_read_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        arvalid_a, arready_a, rvalid_a, rready_a, rd_en_a;
    logic [31:0] araddr_a, rdata_a, rd_data_a;
    logic [1:0]  rresp_a;
    logic [3:0]  rd_idx_a;
    logic [2:0]  outst_a;

    logic        arvalid_b, arready_b, rvalid_b, rready_b, rd_en_b;
    logic [31:0] araddr_b;
    logic [63:0] rdata_b, rd_data_b, d1_b, d2_b;
    logic [1:0]  rresp_b;
    logic [3:0]  rd_idx_b;
    logic [2:0]  outst_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_read_responder u_dut_a (
        .clk           (clk),
        .i_reset       (rst),
        .i_arvalid     (arvalid_a),
        .o_arready     (arready_a),
        .i_araddr      (araddr_a),
        .o_rvalid      (rvalid_a),
        .i_rready      (rready_a),
        .o_rdata       (rdata_a),
        .o_rresp       (rresp_a),
        .o_reg_rd_en   (rd_en_a),
        .o_reg_rd_idx  (rd_idx_a),
        .i_reg_rd_data (rd_data_a),
        .o_outstanding (outst_a)
    );

    axil_read_responder #(
        .DATA_WIDTH (64),
        .RD_LATENCY (3)
    ) u_dut_b (
        .clk           (clk),
        .i_reset       (rst),
        .i_arvalid     (arvalid_b),
        .o_arready     (arready_b),
        .i_araddr      (araddr_b),
        .o_rvalid      (rvalid_b),
        .i_rready      (rready_b),
        .o_rdata       (rdata_b),
        .o_rresp       (rresp_b),
        .o_reg_rd_en   (rd_en_b),
        .o_reg_rd_idx  (rd_idx_b),
        .i_reg_rd_data (rd_data_b),
        .o_outstanding (outst_b)
    );

    // Register contents seen by instance a.
    function automatic logic [31:0] reg_a(input int i);
        return (i == 2) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Register files: data appears exactly RD_LATENCY cycles after the strobe,
    // and garbage otherwise so a wrong sampling point is visible.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? reg_a(int'(rd_idx_a)) : 32'hBAD0_BAD0;
        d1_b      <= rd_en_b ? {32'h1234_5678, 28'h0, rd_idx_b} : 64'hBAD0_BAD0_BAD0_BAD0;
        d2_b      <= d1_b;
        rd_data_b <= d2_b;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int beats, data_err, gaps, ar_stall, stale, early;
        logic [31:0] exp_q[$];

        rst = 1'b1;
        arvalid_a = 1'b1; araddr_a = 32'h8; rready_a = 1'b0;
        arvalid_b = 1'b0; araddr_b = 32'h0; rready_b = 1'b1;

        // Reset values, with a request pending that must not be taken.
        tick(); tick(); #1;
        check("rst_arready", 64'(arready_a), 64'd0);
        check("rst_rd_en", 64'(rd_en_a), 64'd0);
        check("rst_rd_idx", 64'(rd_idx_a), 64'd0);
        check("rst_rvalid", 64'(rvalid_a), 64'd0);
        check("rst_rdata", 64'(rdata_a), 64'd0);
        check("rst_rresp", 64'(rresp_a), 64'd0);
        check("rst_outst", 64'(outst_a), 64'd0);
        tick(); rst = 1'b0; arvalid_a = 1'b0; #1;
        check("post_rst_outst", 64'(outst_a), 64'd0);
        check("post_rst_rvalid", 64'(rvalid_a), 64'd0);
        tick(); #1;
        check("post_rst_arready", 64'(arready_a), 64'd1);

        // Single in-range read.
        rready_a = 1'b1;
        tick(); arvalid_a = 1'b1; araddr_a = 32'h8; #1;
        check("single_rd_en", 64'(rd_en_a), 64'd1);
        check("single_rd_idx", 64'(rd_idx_a), 64'd2);
        tick(); arvalid_a = 1'b0; #1;
        check("single_rvalid_t1", 64'(rvalid_a), 64'd0);
        check("single_outst_t1", 64'(outst_a), 64'd1);
        tick(); #1;
        check("single_rvalid_t2", 64'(rvalid_a), 64'd1);
        check("single_rdata", 64'(rdata_a), 64'hDEAD_BEEF);
        check("single_rresp", 64'(rresp_a), 64'd0);
        tick(); #1;
        check("single_idle_rvalid", 64'(rvalid_a), 64'd0);
        check("single_idle_rdata", 64'(rdata_a), 64'd0);
        check("single_idle_outst", 64'(outst_a), 64'd0);

        // Out-of-range then misaligned.
        tick(); arvalid_a = 1'b1; araddr_a = 32'h40; #1;
        check("oor_rd_en", 64'(rd_en_a), 64'd0);
        check("oor_arready", 64'(arready_a), 64'd1);
        tick(); araddr_a = 32'h6; #1;
        check("misal_rd_en", 64'(rd_en_a), 64'd0);
        tick(); arvalid_a = 1'b0; #1;
        check("oor_rvalid", 64'(rvalid_a), 64'd1);
        check("oor_rresp", 64'(rresp_a), 64'd2);
        check("oor_rdata", 64'(rdata_a), 64'd0);
        tick(); #1;
        check("misal_rvalid", 64'(rvalid_a), 64'd1);
        check("misal_rresp", 64'(rresp_a), 64'd2);
        check("misal_rdata", 64'(rdata_a), 64'd0);
        tick(); #1;
        check("err_drained", 64'(rvalid_a), 64'd0);

        // Back-pressure until full, then drain while the last two are accepted.
        rready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); arvalid_a = 1'b1; araddr_a = 32'(i * 4); #1;
            check("fill_arready", 64'(arready_a), 64'd1);
        end
        tick(); araddr_a = 32'h10; #1;
        check("full_arready", 64'(arready_a), 64'd0);
        check("full_outst", 64'(outst_a), 64'd4);
        check("full_rdata", 64'(rdata_a), 64'(reg_a(0)));
        tick(); #1;
        check("full_rdata_held", 64'(rdata_a), 64'(reg_a(0)));
        check("full_rvalid_held", 64'(rvalid_a), 64'd1);
        tick(); rready_a = 1'b1; #1;
        check("pop_full_arready", 64'(arready_a), 64'd0);
        check("drain_beat0", 64'(rdata_a), 64'(reg_a(0)));
        tick(); #1;
        check("after_pop_arready", 64'(arready_a), 64'd1);
        check("after_pop_outst", 64'(outst_a), 64'd3);
        check("drain_beat1", 64'(rdata_a), 64'(reg_a(1)));
        tick(); araddr_a = 32'h14; #1;
        check("drain_arready", 64'(arready_a), 64'd1);
        check("drain_beat2", 64'(rdata_a), 64'(reg_a(2)));
        tick(); arvalid_a = 1'b0; #1;
        check("drain_beat3", 64'(rdata_a), 64'(reg_a(3)));
        tick(); #1;
        check("drain_beat4", 64'(rdata_a), 64'(reg_a(4)));
        tick(); #1;
        check("drain_beat5", 64'(rdata_a), 64'(reg_a(5)));
        tick(); #1;
        check("drain_empty", 64'(rvalid_a), 64'd0);
        check("drain_outst", 64'(outst_a), 64'd0);

        // Accept and pop in the same cycle at two outstanding.
        rready_a = 1'b0;
        tick(); arvalid_a = 1'b1; araddr_a = 32'h0;
        tick(); araddr_a = 32'h4;
        tick(); arvalid_a = 1'b0;
        tick(); arvalid_a = 1'b1; araddr_a = 32'h8; rready_a = 1'b1; #1;
        check("both_outst_before", 64'(outst_a), 64'd2);
        check("both_arready", 64'(arready_a), 64'd1);
        check("both_rdata", 64'(rdata_a), 64'(reg_a(0)));
        tick(); arvalid_a = 1'b0; #1;
        check("both_outst_after", 64'(outst_a), 64'd2);
        check("both_beat1", 64'(rdata_a), 64'(reg_a(1)));
        tick(); #1;
        check("both_beat2", 64'(rdata_a), 64'(reg_a(2)));
        tick(); #1;
        check("both_outst_end", 64'(outst_a), 64'd0);

        // Streaming: 100 back-to-back reads, one beat per cycle.
        beats = 0; data_err = 0; gaps = 0; ar_stall = 0;
        for (int k = 0; k < 104; k++) begin
            tick();
            arvalid_a = (k < 100);
            araddr_a  = 32'(((k * 5) % 16) * 4);
            if (k < 100) exp_q.push_back(reg_a((k * 5) % 16));
            #1;
            if (k < 100 && !arready_a) ar_stall++;
            if (rvalid_a) begin
                beats++;
                if (exp_q.size() == 0) begin
                    data_err++;
                end else begin
                    if (rdata_a !== exp_q[0]) data_err++;
                    void'(exp_q.pop_front());
                end
            end else if (k >= 2 && k <= 101) begin
                gaps++;
            end
        end
        check("stream_beats", 64'(beats), 64'd100);
        check("stream_data_err", 64'(data_err), 64'd0);
        check("stream_gaps", 64'(gaps), 64'd0);
        check("stream_ar_stall", 64'(ar_stall), 64'd0);

        // Reset with three reads in flight.
        rready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); arvalid_a = 1'b1; araddr_a = 32'(i * 4);
        end
        tick(); arvalid_a = 1'b0; rst = 1'b1; #1;
        check("midrst_rvalid", 64'(rvalid_a), 64'd0);
        check("midrst_arready", 64'(arready_a), 64'd0);
        tick(); rst = 1'b0; rready_a = 1'b1; #1;
        check("midrst_rvalid_after", 64'(rvalid_a), 64'd0);
        check("midrst_outst_after", 64'(outst_a), 64'd0);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            if (rvalid_a) stale++;
        end
        check("midrst_stale", 64'(stale), 64'd0);
        tick(); arvalid_a = 1'b1; araddr_a = 32'h8;
        tick(); arvalid_a = 1'b0;
        tick(); #1;
        check("midrst_new_rvalid", 64'(rvalid_a), 64'd1);
        check("midrst_new_rdata", 64'(rdata_a), 64'hDEAD_BEEF);
        check("midrst_new_rresp", 64'(rresp_a), 64'd0);

        // 64-bit bus, three-cycle register latency.
        tick(); arvalid_b = 1'b1; araddr_b = 32'h18; #1;
        check("b_arready", 64'(arready_b), 64'd1);
        check("b_rd_en", 64'(rd_en_b), 64'd1);
        check("b_rd_idx", 64'(rd_idx_b), 64'd3);
        early = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); arvalid_b = 1'b0; #1;
            if (rvalid_b) early++;
        end
        check("b_early", 64'(early), 64'd0);
        tick(); #1;
        check("b_rvalid", 64'(rvalid_b), 64'd1);
        check("b_rdata", rdata_b, 64'h1234_5678_0000_0003);
        check("b_rresp", 64'(rresp_b), 64'd0);
        tick(); #1;
        check("b_idle", 64'(rvalid_b), 64'd0);
        check("b_outst", 64'(outst_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
